mem_transfer_ctrl: RTL and testbench

- Sequences lw/sw data transfers and instruction fetches onto one shared single-port data/instruction memory.
- Sits between decode/execute (data-transfer requester) and the memory.
- Computes the effective address (base + offset) and validates the instruction ID.
- Arbitrates between the fetch and data requesters; runs a req/ack handshake with a variable-latency memory.

---
 rtl/mem_transfer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_transfer_ctrl.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_transfer_ctrl.sv
// mem_transfer_ctrl: sequences lw/sw data transfers and instruction fetches onto one shared single-port memory.
// Latency: req sampled -> done pulse takes 3 cycles with an immediate mem_ack (IDLE, ACCESS, RESP); an illegal data op takes 2 (IDLE, RESP).
// Backpressure: requesters hold req until their done pulse; the memory stalls by withholding mem_ack (no timeout).
//
// Ports:
//   clk, reset       rising-edge clock; synchronous active-low reset (reset=0 resets)
//   if_*             fetch requester: if_req/if_addr in, if_done pulse + if_rdata out
//   dt_*             data requester: dt_req/dt_id/dt_base/dt_off/dt_wdata in,
//                    dt_done pulse + dt_err + dt_rdata out
//   mem_*            memory side: mem_req held until mem_ack, mem_we/mem_addr/mem_wdata
//                    stable while mem_req=1, mem_rdata valid with mem_ack
//   busy             1 whenever the controller is not idle
//
// Configuration: define MEM_TRANSFER_RR_ARB_EN for round-robin arbitration between the
// two requesters; without it the data requester always wins a tie.

module mem_transfer_ctrl #(
    parameter int ADDR_W = 10,
    parameter int LW_ID  = 13,
    parameter int SW_ID  = 14
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,

    input  logic              dt_req,
    input  logic [31:0]       dt_id,
    input  logic [31:0]       dt_base,
    input  logic [31:0]       dt_off,
    input  logic [31:0]       dt_wdata,
    output logic              dt_done,
    output logic              dt_err,
    output logic [31:0]       dt_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // Owner of the transfer currently in ACCESS/RESP: 1 = data requester, 0 = fetch.
    logic serve_data;

    // ------------------------------------------------------------------
    // Data-op decode, evaluated combinationally while IDLE samples dt_req.
    // ------------------------------------------------------------------
    logic [31:0] eff_addr;
    logic        is_lw;
    logic        is_sw;
    logic        addr_oor;
    logic        data_illegal;

    // 32-bit wrap-around sum; the offset arrives already sign-extended.
    assign eff_addr = dt_base + dt_off;

    assign is_lw = (dt_id == 32'(LW_ID));
    assign is_sw = (dt_id == 32'(SW_ID));

    // A negative sum has bit 31 set, so one test on the upper bits covers
    // both "negative" and "past the last word".
    assign addr_oor = (eff_addr[31:ADDR_W] != '0);

    assign data_illegal = !(is_lw || is_sw) || addr_oor;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic grant_data;

`ifdef MEM_TRANSFER_RR_ARB_EN
    // Tie-break pointer: 1 = data wins a simultaneous request. It flips to the
    // other requester after every grant, errored data ops included.
    logic ptr_data;

    assign grant_data = dt_req && (!if_req || ptr_data);
`else
    // Fixed priority: any pending data request beats a fetch.
    assign grant_data = dt_req;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            serve_data <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            dt_done    <= 1'b0;
            dt_err     <= 1'b0;
            dt_rdata   <= '0;
            busy       <= 1'b0;
`ifdef MEM_TRANSFER_RR_ARB_EN
            ptr_data   <= 1'b1;
`endif
        end else begin
            // Done pulses (and the error flag that qualifies dt_done) last one cycle.
            if_done <= 1'b0;
            dt_done <= 1'b0;
            dt_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (dt_req || if_req) begin
                        busy       <= 1'b1;
                        serve_data <= grant_data;
`ifdef MEM_TRANSFER_RR_ARB_EN
                        ptr_data   <= !grant_data;
`endif
                        if (grant_data && data_illegal) begin
                            // Rejected op never touches the memory.
                            state    <= RESP;
                            dt_done  <= 1'b1;
                            dt_err   <= 1'b1;
                            dt_rdata <= '0;
                        end else if (grant_data) begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_sw;
                            mem_addr  <= eff_addr[ADDR_W-1:0];
                            mem_wdata <= is_sw ? dt_wdata : 32'd0;
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end

                ACCESS: begin
                    // Request fields stay frozen until the memory acknowledges.
                    if (mem_ack) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (serve_data) begin
                            dt_done  <= 1'b1;
                            // mem_we still marks a store here; stores return zero.
                            dt_rdata <= mem_we ? 32'd0 : mem_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end

                RESP: begin
                    // Requests are not sampled here, so the requester has this
                    // cycle to drop req after seeing its done pulse.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_transfer_ctrl.sv
// tb_mem_transfer_ctrl: self-checking bench for mem_transfer_ctrl.
// Expected values come from a small reference model (address arithmetic,
// legality rule, arbitration winner) and from constants given for each scenario.

module tb_mem_transfer_ctrl;

    localparam int          AW = 10;
    localparam logic [31:0] LW = 32'd13;
    localparam logic [31:0] SW = 32'd14;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          dt_req;
    logic [31:0]   dt_id;
    logic [31:0]   dt_base;
    logic [31:0]   dt_off;
    logic [31:0]   dt_wdata;
    logic          dt_done;
    logic          dt_err;
    logic [31:0]   dt_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: 1 when the most recent grant went to the data requester.
    bit m_last_data;

    // Observations from one transfer, filled in by obs().
    logic          o_to, o_unst, o_saw, o_req_at_done, o_err, o_we;
    logic [7:0]    o_dtd, o_ifd, o_lat, o_busy;
    logic [AW-1:0] o_addr;
    logic [31:0]   o_wdata, o_dt_rdata, o_if_rdata;

    always #5 clk = ~clk;

    mem_transfer_ctrl #(.ADDR_W(AW), .LW_ID(13), .SW_ID(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dt_req    (dt_req),
        .dt_id     (dt_id),
        .dt_base   (dt_base),
        .dt_off    (dt_off),
        .dt_wdata  (dt_wdata),
        .dt_done   (dt_done),
        .dt_err    (dt_err),
        .dt_rdata  (dt_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic bit model_illegal(input logic [31:0] id, input logic [31:0] base,
                                         input logic [31:0] off);
        int s;
        s = int'(base) + int'(off);
        return !(id == LW || id == SW) || s < 0 || s >= (1 << AW);
    endfunction

    function automatic bit model_data_wins(input bit d, input bit f);
`ifdef MEM_TRANSFER_RR_ARB_EN
        if (d && f) return !m_last_data;
`endif
        if (!f) return d;
        return d;
    endfunction

    // ---------------- memory responder / observer ----------------
    // Runs until a done pulse (or a 60-cycle bound). Acks the memory request
    // in its (dly+1)-th cycle. o_lat counts clock edges from the call to the
    // edge that raised done; o_busy counts sampled cycles with busy=1.
    task automatic obs(input int dly, input logic [31:0] rd);
        int n;
        int reqc;
        bit fin;
        n = 0; reqc = 0; fin = 0;
        o_to = 0; o_unst = 0; o_saw = 0; o_req_at_done = 0; o_err = 0; o_we = 0;
        o_dtd = 0; o_ifd = 0; o_lat = 0; o_busy = 0;
        o_addr = '0; o_wdata = '0; o_dt_rdata = '0; o_if_rdata = '0;
        while (!fin) begin
            @(posedge clk); #1;
            n++;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (busy)    o_busy++;
            if (dt_done) o_dtd++;
            if (if_done) o_ifd++;
            if (dt_done || if_done) begin
                fin           = 1;
                o_lat         = 8'(n);
                o_req_at_done = mem_req;
                o_err         = dt_err;
                o_dt_rdata    = dt_rdata;
                o_if_rdata    = if_rdata;
                if (dt_done) dt_req = 1'b0;
                if (if_done) if_req = 1'b0;
            end else if (mem_req) begin
                if (!o_saw) begin
                    o_saw = 1; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wdata} !== {o_addr, o_we, o_wdata}) begin
                    o_unst = 1;
                end
                if (reqc == dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd;
                end
                reqc++;
            end
            if (!fin && n >= 60) begin
                fin  = 1;
                o_to = 1;
            end
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [127:0] got;
        reset = 1'b0; dt_req = 1'b1; if_req = 1'b1; mem_ack = 1'b1;
        dt_id = LW; dt_base = 32'd3; dt_off = 32'd4; dt_wdata = $urandom;
        if_addr = 10'd9; mem_rdata = $urandom;
        repeat (3) @(posedge clk);
        #1;
        got = 128'({mem_req, mem_we, mem_addr, mem_wdata, if_done, if_rdata, dt_done, dt_err, dt_rdata, busy});
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, want 0", got);
        end
        dt_req = 1'b0; if_req = 1'b0; mem_ack = 1'b0; reset = 1'b1;
        m_last_data = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, mem_req, dt_done, if_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b, want 0000", {busy, mem_req, dt_done, if_done});
        end
    endtask

    task automatic test_lw();
        logic [127:0] got, exp;
        dt_req = 1'b1; dt_id = LW; dt_base = 32'd10; dt_off = 32'd12; dt_wdata = $urandom;
        obs(2, 32'hDEADBEEF);
        m_last_data = 1'b1;
        got = 128'({o_to, o_unst, o_req_at_done, o_dtd, o_ifd});
        exp = 128'({3'b000, 8'd1, 8'd0});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL lw_handshake: got %h, want %h", got, exp); end
        got = 128'({o_saw, o_addr, o_we, o_wdata});
        exp = 128'({1'b1, 10'd22, 1'b0, 32'd0});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL lw_mem: got %h, want %h", got, exp); end
        got = 128'({o_err, o_dt_rdata});
        exp = 128'({1'b0, 32'hDEADBEEF});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL lw_resp: got %h, want %h", got, exp); end
        got = 128'({o_lat, o_busy});
        exp = 128'({8'd4, 8'd4});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL lw_timing: got %h, want %h", got, exp); end
    endtask

    task automatic test_sw();
        logic [127:0] got, exp;
        int dly;
        dly = $urandom_range(0, 3);
        dt_req = 1'b1; dt_id = SW; dt_base = 32'd10; dt_off = 32'd100; dt_wdata = 32'd55;
        obs(dly, $urandom);
        m_last_data = 1'b1;
        got = 128'({o_to, o_unst, o_req_at_done, o_dtd, o_ifd});
        exp = 128'({3'b000, 8'd1, 8'd0});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL sw_handshake: got %h, want %h", got, exp); end
        got = 128'({o_saw, o_addr, o_we, o_wdata});
        exp = 128'({1'b1, 10'd110, 1'b1, 32'd55});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL sw_mem: got %h, want %h", got, exp); end
        got = 128'({o_err, o_dt_rdata});
        exp = 128'({1'b0, 32'd0});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL sw_resp: got %h, want %h", got, exp); end
        got = 128'({o_lat, o_busy});
        exp = 128'({8'(dly + 2), 8'(dly + 2)});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL sw_timing: got %h, want %h", got, exp); end
    endtask

    task automatic test_contention();
        logic [31:0] rd_d, rd_f;
        bit dfirst, is_d;
        for (int p = 0; p < 2; p++) begin
            dt_req = 1'b1; if_req = 1'b1; if_addr = 10'd4;
            dt_id = LW; dt_base = 32'd10; dt_off = 32'd12;
            rd_d = $urandom | 32'd1; rd_f = $urandom;
            dfirst = model_data_wins(1'b1, 1'b1);
            for (int s = 0; s < 2; s++) begin
                is_d = (s == 0) ? dfirst : !dfirst;
                obs($urandom_range(0, 2), is_d ? rd_d : rd_f);
                m_last_data = is_d;
                vectors++;
                if ({o_to, o_dtd, o_ifd} !== {1'b0, is_d ? 8'd1 : 8'd0, is_d ? 8'd0 : 8'd1}) begin
                    miscompares++;
                    $display("FAIL contention_winner pair %0d slot %0d: got dt=%0d if=%0d to=%0b, want data_first=%0b",
                             p, s, o_dtd, o_ifd, o_to, dfirst);
                end
                vectors++;
                if ({o_addr, o_we} !== {is_d ? 10'd22 : 10'd4, 1'b0}) begin
                    miscompares++;
                    $display("FAIL contention_addr pair %0d slot %0d: got %0d we=%b, want %0d we=0",
                             p, s, o_addr, o_we, is_d ? 22 : 4);
                end
                vectors++;
                if ((is_d ? o_dt_rdata : o_if_rdata) !== (is_d ? rd_d : rd_f)) begin
                    miscompares++;
                    $display("FAIL contention_rdata pair %0d slot %0d: got %h, want %h",
                             p, s, is_d ? o_dt_rdata : o_if_rdata, is_d ? rd_d : rd_f);
                end
            end
            dt_req = 1'b0; if_req = 1'b0;
        end
    endtask

    task automatic test_errors();
        logic [31:0] e_id [3];
        logic [31:0] e_base [3];
        logic [31:0] e_off [3];
        logic [127:0] got, exp;
        e_id[0] = 32'd13; e_base[0] = 32'd1000; e_off[0] = 32'd100;
        e_id[1] = 32'd7;  e_base[1] = 32'd10;   e_off[1] = 32'd12;
        e_id[2] = 32'd14; e_base[2] = 32'd5;    e_off[2] = 32'hFFFF_FFFA;
        for (int i = 0; i < 3; i++) begin
            dt_req = 1'b1; dt_id = e_id[i]; dt_base = e_base[i]; dt_off = e_off[i];
            dt_wdata = $urandom;
            obs(0, $urandom);
            m_last_data = 1'b1;
            got = 128'({o_to, o_dtd, o_ifd, o_saw, o_req_at_done});
            exp = 128'({1'b0, 8'd1, 8'd0, 1'b0, 1'b0});
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL err%0d_handshake: got %h, want %h", i, got, exp); end
            got = 128'({o_err, o_dt_rdata});
            exp = 128'({1'b1, 32'd0});
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL err%0d_resp: got %h, want %h", i, got, exp); end
            got = 128'({o_lat, o_busy});
            exp = 128'({8'd1, 8'd1});
            vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL err%0d_timing: got %h, want %h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid_access();
        int n;
        logic [31:0] rd;
        logic [127:0] got, exp;
        dt_req = 1'b1; dt_id = LW; dt_base = 32'd10; dt_off = 32'd12;
        n = 0;
        while (!mem_req && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (mem_req !== 1'b1) begin miscompares++; $display("FAIL midrst_access: got mem_req=%b, want 1", mem_req); end
        reset = 1'b0; dt_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({mem_req, busy, dt_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_abort: got req/busy/done=%b, want 000", {mem_req, busy, dt_done});
        end
        reset = 1'b1; m_last_data = 1'b0;
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        vectors++;
        if ({mem_req, busy, dt_done, if_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_late_ack: got %b, want 0000", {mem_req, busy, dt_done, if_done});
        end
        rd = $urandom;
        dt_req = 1'b1; dt_id = LW; dt_base = 32'd200; dt_off = 32'd3;
        obs(1, rd);
        m_last_data = 1'b1;
        got = 128'({o_to, o_dtd, o_ifd, o_saw, o_addr, o_we});
        exp = 128'({1'b0, 8'd1, 8'd0, 1'b1, 10'd203, 1'b0});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL midrst_lw_mem: got %h, want %h", got, exp); end
        got = 128'({o_err, o_dt_rdata, o_lat, o_busy});
        exp = 128'({1'b0, rd, 8'd3, 8'd3});
        vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL midrst_lw_resp: got %h, want %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0]   rd [3];
        logic [AW-1:0] ad [3];
        int k, n;
        bit acked;
        for (int i = 0; i < 3; i++) begin
            rd[i] = $urandom;
            ad[i] = AW'($urandom);
        end
        k = 0; n = 0; acked = 0;
        if_req = 1'b1; if_addr = ad[0];
        while (k < 3 && n < 40) begin
            @(posedge clk); #1;
            n++;
            mem_ack = 1'b0;
            if (if_done) begin
                vectors++;
                if (if_rdata !== rd[k]) begin
                    miscompares++;
                    $display("FAIL b2b_rdata%0d: got %h, want %h", k, if_rdata, rd[k]);
                end
                vectors++;
                if (n !== 2 + 3 * k) begin
                    miscompares++;
                    $display("FAIL b2b_spacing%0d: got done at cycle %0d, want %0d", k, n, 2 + 3 * k);
                end
                k++;
                if_req = 1'b0;
            end else begin
                if (k < 3 && !if_req) begin
                    if_req  = 1'b1;
                    if_addr = ad[k];
                end
                if (mem_req && !acked) begin
                    vectors++;
                    if ({mem_addr, mem_we} !== {ad[k], 1'b0}) begin
                        miscompares++;
                        $display("FAIL b2b_addr%0d: got %0d we=%b, want %0d we=0", k, mem_addr, mem_we, ad[k]);
                    end
                    mem_ack   = 1'b1;
                    mem_rdata = rd[k];
                end
            end
            acked = mem_ack;
        end
        vectors++;
        if (k !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d fetches, want 3", k); end
        if_req = 1'b0;
        m_last_data = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] id, base, off, wd, sum, rd, exp_rdata, exp_wdata;
        bit illegal, is_d, exp_we;
        int dly, guard;
        logic [127:0] got, exp;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       id = LW;
                1:       id = SW;
                2:       id = LW;
                default: id = $urandom_range(0, 31);
            endcase
            base = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1100);
            off  = $urandom_range(0, 600) - 300;
            wd   = $urandom;
            sum  = base + off;
            illegal = model_illegal(id, base, off);
            dt_id = id; dt_base = base; dt_off = off; dt_wdata = wd;
            if_addr = AW'($urandom);
            case ($urandom_range(0, 2))
                0:       begin dt_req = 1'b1; if_req = 1'b0; end
                1:       begin dt_req = 1'b0; if_req = 1'b1; end
                default: begin dt_req = 1'b1; if_req = 1'b1; end
            endcase
            guard = 0;
            while ((dt_req || if_req) && guard < 2) begin
                guard++;
                is_d = model_data_wins(dt_req, if_req);
                dly  = $urandom_range(0, 3);
                rd   = $urandom;
                obs(dly, rd);
                m_last_data = is_d;
                got = 128'({o_to, o_unst, o_req_at_done, o_dtd, o_ifd});
                exp = 128'({3'b000, is_d ? 8'd1 : 8'd0, is_d ? 8'd0 : 8'd1});
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL rnd%0d_handshake: got %h, want %h", it, got, exp);
                end
                if (is_d && illegal) begin
                    got = 128'({o_saw, o_err, o_dt_rdata, o_lat, o_busy});
                    exp = 128'({1'b0, 1'b1, 32'd0, 8'd1, 8'd1});
                    vectors++;
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL rnd%0d_illegal: got %h, want %h", it, got, exp);
                    end
                end else if (is_d) begin
                    exp_we    = (id == SW);
                    exp_wdata = exp_we ? wd : 32'd0;
                    exp_rdata = exp_we ? 32'd0 : rd;
                    got = 128'({o_saw, o_addr, o_we, o_wdata});
                    exp = 128'({1'b1, sum[AW-1:0], exp_we, exp_wdata});
                    vectors++;
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL rnd%0d_data_mem: got %h, want %h", it, got, exp);
                    end
                    got = 128'({o_err, o_dt_rdata, o_lat, o_busy});
                    exp = 128'({1'b0, exp_rdata, 8'(dly + 2), 8'(dly + 2)});
                    vectors++;
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL rnd%0d_data_resp: got %h, want %h", it, got, exp);
                    end
                end else begin
                    got = 128'({o_saw, o_addr, o_we, o_wdata, o_if_rdata, o_lat});
                    exp = 128'({1'b1, if_addr, 1'b0, 32'd0, rd, 8'(dly + 2)});
                    vectors++;
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL rnd%0d_fetch: got %h, want %h", it, got, exp);
                    end
                end
            end
            dt_req = 1'b0; if_req = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; dt_req = 1'b0; dt_id = '0;
        dt_base = '0; dt_off = '0; dt_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        m_last_data = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_contention();
        test_errors();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1);
    end

endmodule
